// File: rtl/float_cmp_pkg.sv
// Shared constants for the compare scheduler: result codes, FSM encoding
// and operand width.
package float_cmp_pkg;

    localparam int OPW = 32;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/float_compare_sched_if.sv
// Request, response and compare-unit signals of the compare scheduler.
// The scheduler uses the slave modport; its environment uses master.
interface float_compare_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]                     req_valid;
    logic [NREQ-1:0]                     req_ready;
    logic [NREQ*float_cmp_pkg::OPW-1:0]  req_a;
    logic [NREQ*float_cmp_pkg::OPW-1:0]  req_b;
    logic                                rsp_valid;
    logic                                rsp_ready;
    logic [IDW-1:0]                      rsp_id;
    logic [1:0]                          rsp_result;
    logic [float_cmp_pkg::OPW-1:0]       cmp_a;
    logic [float_cmp_pkg::OPW-1:0]       cmp_b;
    logic                                cmp_enable;
    logic [1:0]                          cmp_out;
    logic                                busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, cmp_out,
        input  req_ready, rsp_valid, rsp_id, rsp_result, cmp_a, cmp_b, cmp_enable, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, cmp_out,
        output req_ready, rsp_valid, rsp_id, rsp_result, cmp_a, cmp_b, cmp_enable, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic found_s;
    int   idx_s;

    // Scan from ptr; NREQ need not be a power of two, so wrap with modulo.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = (int'(ptr) + k) % NREQ;
            if (!found_s && req[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                gnt_id     = IDW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/float_compare_sched.sv
// Shares one floating-point compare unit between NREQ requesters: one
// operation in flight, round-robin grant, back-pressured response.
module float_compare_sched
    import float_cmp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int CMP_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    float_compare_sched_if.slave bus
);

    localparam logic [3:0]     LAT_C   = 4'(CMP_LAT);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_e          state_r;
    state_e          state_s;
    logic            grant_s;
    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  gnt_id_s;
    logic [IDW-1:0]  ptr_r;
    logic [IDW-1:0]  id_r;
    logic [3:0]      cnt_r;
    logic [1:0]      result_r;
    logic [OPW-1:0]  a_r;
    logic [OPW-1:0]  b_r;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (bus.req_valid),
        .ptr    (ptr_r),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s)
    );

    // Next-state logic; a grant happens on any IDLE cycle with a request.
    always_comb begin
        state_s = state_r;
        grant_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    state_s = ST_ISSUE;
                    grant_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if ((cnt_r + 4'd1) == LAT_C) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant bookkeeping: operands, owner ID and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
            id_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
        end else if (grant_s) begin
            ptr_r <= (gnt_id_s == LAST_ID) ? '0 : gnt_id_s + IDW'(1);
            id_r  <= gnt_id_s;
            a_r   <= bus.req_a[OPW*int'(gnt_id_s) +: OPW];
            b_r   <= bus.req_b[OPW*int'(gnt_id_s) +: OPW];
        end
    end

    // Latency counter; the result is sampled on the edge it reaches CMP_LAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 4'd0;
            result_r <= 2'b00;
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= 4'd0;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 4'd1;
            if ((cnt_r + 4'd1) == LAT_C) begin
                result_r <= bus.cmp_out;
            end
        end
    end

    // req_valid is ignored while reset is asserted.
    assign bus.req_ready  = ((state_r == ST_IDLE) && rst_n) ? gnt_s : '0;
    assign bus.rsp_valid  = (state_r == ST_RESP);
    assign bus.rsp_id     = id_r;
    assign bus.rsp_result = result_r;
    assign bus.cmp_a      = a_r;
    assign bus.cmp_b      = b_r;
    assign bus.cmp_enable = (state_r == ST_ISSUE);
    assign bus.busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_float_compare_sched.sv
// Self-checking bench: dut0 (CMP_LAT=1) and dut1 (CMP_LAT=4), each with a
// behavioural compare-unit model that presents the answer only on its due cycle.
module tb_float_compare_sched;
    import float_cmp_pkg::*;

    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NR-1:0]   rv [2];
    logic [NR*32-1:0] ra [2];
    logic [NR*32-1:0] rb [2];
    logic            rr [2];
    logic [1:0]      co [2];

    logic [NR-1:0]   o_rdy [2];
    logic            o_rv [2];
    logic [1:0]      o_id [2];
    logic [1:0]      o_res [2];
    logic [31:0]     o_ca [2];
    logic [31:0]     o_cb [2];
    logic            o_en [2];
    logic            o_busy [2];

    float_compare_sched_if #(.NREQ(NR), .IDW(2)) bus0 ();
    float_compare_sched_if #(.NREQ(NR), .IDW(2)) bus1 ();

    assign bus0.req_valid = rv[0];
    assign bus0.req_a     = ra[0];
    assign bus0.req_b     = rb[0];
    assign bus0.rsp_ready = rr[0];
    assign bus0.cmp_out   = co[0];
    assign bus1.req_valid = rv[1];
    assign bus1.req_a     = ra[1];
    assign bus1.req_b     = rb[1];
    assign bus1.rsp_ready = rr[1];
    assign bus1.cmp_out   = co[1];

    assign o_rdy[0] = bus0.req_ready;   assign o_rdy[1] = bus1.req_ready;
    assign o_rv[0]  = bus0.rsp_valid;   assign o_rv[1]  = bus1.rsp_valid;
    assign o_id[0]  = bus0.rsp_id;      assign o_id[1]  = bus1.rsp_id;
    assign o_res[0] = bus0.rsp_result;  assign o_res[1] = bus1.rsp_result;
    assign o_ca[0]  = bus0.cmp_a;       assign o_ca[1]  = bus1.cmp_a;
    assign o_cb[0]  = bus0.cmp_b;       assign o_cb[1]  = bus1.cmp_b;
    assign o_en[0]  = bus0.cmp_enable;  assign o_en[1]  = bus1.cmp_enable;
    assign o_busy[0] = bus0.busy;       assign o_busy[1] = bus1.busy;

    float_compare_sched #(.NREQ(NR), .IDW(2), .CMP_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    float_compare_sched #(.NREQ(NR), .IDW(2), .CMP_LAT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // IEEE-754 ordering for non-NaN values; +0 and -0 compare equal.
    function automatic logic [1:0] fcmp(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return CMP_EQ;
        if (a == b) return CMP_EQ;
        if (a[31] != b[31]) return a[31] ? CMP_LT : CMP_GT;
        if (!a[31]) return (a[30:0] > b[30:0]) ? CMP_GT : CMP_LT;
        return (a[30:0] > b[30:0]) ? CMP_LT : CMP_GT;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        if (v[30:23] == 8'hFF) v[30] = 1'b0;
        return v;
    endfunction

    // Compare-unit model: correct code only exactly CMP_LAT edges after enable.
    logic       act [2];
    int         kk [2];
    logic [1:0] code [2];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                act[d] = 1'b0;
                kk[d]  = 0;
            end else if (o_en[d]) begin
                act[d]  = 1'b1;
                kk[d]   = 0;
                code[d] = fcmp(o_ca[d], o_cb[d]);
            end else if (act[d]) begin
                kk[d]++;
            end
            co[d] = (act[d] && kk[d] == ((d == 0) ? 1 : 4)) ? code[d] : ~code[d];
        end
    end

    task automatic check_reset_outs(input int d);
        chk("rst_req_ready", 64'(o_rdy[d]), 64'(0));
        chk("rst_rsp_valid", 64'(o_rv[d]), 64'(0));
        chk("rst_rsp_id", 64'(o_id[d]), 64'(0));
        chk("rst_rsp_result", 64'(o_res[d]), 64'(0));
        chk("rst_cmp_a", 64'(o_ca[d]), 64'(0));
        chk("rst_cmp_b", 64'(o_cb[d]), 64'(0));
        chk("rst_cmp_enable", 64'(o_en[d]), 64'(0));
        chk("rst_busy", 64'(o_busy[d]), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rr[0] = 1'b1; rr[1] = 1'b1;
        rv[0] = 4'hF; rv[1] = 4'hF;
        #1;
        check_reset_outs(0);
        chk("rst_req_ready_dut1", 64'(o_rdy[1]), 64'(0));
        repeat (2) @(negedge clk);
        rv[0] = 4'h0; rv[1] = 4'h0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One operation: call just after a posedge (or earlier in an IDLE cycle).
    task automatic txn(input int d, input logic [3:0] mask, input logic [3:0] after,
                       input int stall, output int gid, output int rid,
                       output logic [1:0] res, output logic [31:0] ca,
                       output int lat, output int wcyc);
        logic [3:0]  g;
        logic [31:0] cb0;
        int          en_cnt;
        rr[d] = (stall == 0);
        rv[d] = mask;
        wcyc = 0;
        @(negedge clk);
        while (o_rdy[d] == 4'b0 && wcyc < 50) begin
            wcyc++;
            @(negedge clk);
        end
        g = o_rdy[d];
        chk("grant_seen", 64'(g != 4'b0), 64'(1));
        chk("grant_onehot", 64'($countones(g)), 64'(1));
        gid = -1;
        for (int i = 0; i < NR; i++) if (g[i]) gid = i;
        @(posedge clk); #1;
        rv[d] = after;
        lat = 0;
        en_cnt = 0;
        while (!o_rv[d] && lat < 40) begin
            @(negedge clk);
            lat++;
            if (o_en[d]) en_cnt++;
        end
        chk("rsp_seen", 64'(o_rv[d]), 64'(1));
        chk("enable_single_pulse", 64'(en_cnt), 64'(1));
        rid = int'(o_id[d]);
        res = o_res[d];
        ca  = o_ca[d];
        cb0 = o_cb[d];
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_hold", 64'(o_rv[d] && o_id[d] == 2'(rid) && o_res[d] == res &&
                                  o_ca[d] == ca && o_cb[d] == cb0), 64'(1));
            chk("stall_no_accept", 64'(o_rdy[d]), 64'(0));
        end
        rr[d] = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int gid, rid, lat, wcyc, eg, ptr_m;
        logic [1:0]  res;
        logic [31:0] ca, sa, sb;
        logic [3:0]  mask;

        vecs[0] = '{1, 32'h3F800000, 32'h40000000, 2'b11};
        vecs[1] = '{0, 32'hC0490FDB, 32'hC0490FDB, 2'b00};
        vecs[2] = '{2, 32'h40000000, 32'h3F800000, 2'b01};
        vecs[3] = '{3, 32'hBF800000, 32'h3F800000, 2'b11};
        vecs[4] = '{0, 32'h00000000, 32'h80000000, 2'b00};
        vecs[5] = '{2, 32'hC0000000, 32'hBF800000, 2'b11};
        vecs[6] = '{1, 32'h7F7FFFFF, 32'hFF7FFFFF, 2'b01};
        vecs[7] = '{3, 32'h00000001, 32'h00000000, 2'b01};

        rst_n = 1'b1;
        ra[0] = '0; rb[0] = '0; ra[1] = '0; rb[1] = '0;
        rv[0] = 4'h0; rv[1] = 4'h0;
        rr[0] = 1'b1; rr[1] = 1'b1;
        do_reset();

        // Table of single requests on the CMP_LAT=1 build.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NR; i++) begin
                ra[0][i*32 +: 32] = $urandom;
                rb[0][i*32 +: 32] = $urandom;
            end
            ra[0][vecs[v].id*32 +: 32] = vecs[v].a;
            rb[0][vecs[v].id*32 +: 32] = vecs[v].b;
            txn(0, 4'(1 << vecs[v].id), 4'h0, 0, gid, rid, res, ca, lat, wcyc);
            chk("vec_grant", 64'(gid), 64'(vecs[v].id));
            chk("vec_rsp_id", 64'(rid), 64'(vecs[v].id));
            chk("vec_result", 64'(res), 64'(vecs[v].exp));
            chk("vec_cmp_a", 64'(ca), 64'(vecs[v].a));
            chk("vec_latency", 64'(lat), 64'(3));
        end

        // Fairness: all requesters held high for eight operations.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            ra[0][i*32 +: 32] = rnd_fp();
            rb[0][i*32 +: 32] = rnd_fp();
        end
        for (int k = 0; k < 8; k++) begin
            txn(0, 4'hF, (k < 7) ? 4'hF : 4'h0, 0, gid, rid, res, ca, lat, wcyc);
            chk("fair_order", 64'(gid), 64'(k % 4));
            chk("fair_result", 64'(res), 64'(fcmp(ra[0][(k%4)*32 +: 32], rb[0][(k%4)*32 +: 32])));
            if (k > 0) chk("fair_one_idle", 64'(wcyc), 64'(0));
        end

        // Back-pressure: requester 2 stays pending through a 10-cycle stall.
        txn(0, 4'b0110, 4'b0100, 10, gid, rid, res, ca, lat, wcyc);
        chk("bp_grant", 64'(gid), 64'(1));
        chk("bp_result", 64'(res), 64'(fcmp(ra[0][32 +: 32], rb[0][32 +: 32])));
        txn(0, 4'b0100, 4'b0000, 0, gid, rid, res, ca, lat, wcyc);
        chk("bp_next_grant", 64'(gid), 64'(2));
        chk("bp_next_delay", 64'(wcyc), 64'(0));

        // Reset in WAIT: requester 1 granted (ptr was 3), then aborted.
        rv[0] = 4'b0010;
        @(negedge clk);
        chk("mid_grant", 64'(o_rdy[0]), 64'(4'b0010));
        @(posedge clk); #1;
        rv[0] = 4'b0000;
        @(negedge clk);
        chk("mid_enable", 64'(o_en[0]), 64'(1));
        @(negedge clk);
        chk("mid_busy", 64'(o_busy[0]), 64'(1));
        #2;
        rst_n = 1'b0;
        rv[0] = 4'hF;
        #1;
        check_reset_outs(0);
        @(negedge clk);
        rv[0] = 4'h0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_no_rsp", 64'(o_rv[0]), 64'(0));
        chk("mid_result_dropped", 64'(o_res[0]), 64'(0));
        txn(0, 4'hF, 4'h0, 0, gid, rid, res, ca, lat, wcyc);
        chk("mid_ptr_zero", 64'(gid), 64'(0));
        chk("mid_rsp_id", 64'(rid), 64'(0));

        // Randomized traffic against a round-robin reference model.
        do_reset();
        ptr_m = 0;
        for (int r = 0; r < 30; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) begin
                ra[0][i*32 +: 32] = rnd_fp();
                rb[0][i*32 +: 32] = ($urandom_range(0, 3) == 0) ? ra[0][i*32 +: 32] : rnd_fp();
            end
            eg = -1;
            for (int k = NR - 1; k >= 0; k--) if (mask[(ptr_m + k) % NR]) eg = (ptr_m + k) % NR;
            sa = ra[0][eg*32 +: 32];
            sb = rb[0][eg*32 +: 32];
            txn(0, mask, 4'h0, $urandom_range(0, 3), gid, rid, res, ca, lat, wcyc);
            chk("rnd_grant", 64'(gid), 64'(eg));
            chk("rnd_rsp_id", 64'(rid), 64'(eg));
            chk("rnd_result", 64'(res), 64'(fcmp(sa, sb)));
            chk("rnd_cmp_a", 64'(ca), 64'(sa));
            chk("rnd_latency", 64'(lat), 64'(3));
            ptr_m = (eg + 1) % NR;
        end

        // CMP_LAT=4 build.
        ra[1][32 +: 32] = 32'h3F800000;
        rb[1][32 +: 32] = 32'h40000000;
        txn(1, 4'b0010, 4'h0, 0, gid, rid, res, ca, lat, wcyc);
        chk("lat4_rsp_id", 64'(rid), 64'(1));
        chk("lat4_result", 64'(res), 64'(2'b11));
        chk("lat4_latency", 64'(lat), 64'(6));
        ra[1][96 +: 32] = 32'h40000000;
        rb[1][96 +: 32] = 32'h3F800000;
        txn(1, 4'b1000, 4'h0, 2, gid, rid, res, ca, lat, wcyc);
        chk("lat4_rsp_id2", 64'(rid), 64'(3));
        chk("lat4_result2", 64'(res), 64'(2'b01));
        chk("lat4_latency2", 64'(lat), 64'(6));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
